// File: rtl/move_tile_ctrl_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : move_tile_ctrl_if
// Description : Handshake bundle between the tile-move sequencer (master)
//               and the MoveZero blank-routing engine (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface move_tile_ctrl_if;
    logic                   o_mz_start;     // 1-cycle start pulse to MoveZero
    logic [3:0][3:0][3:0]   o_mz_klotski;   // working board handed to MoveZero
    logic [3:0][3:0]        o_mz_mask;      // cells MoveZero must not disturb
    logic [1:0][1:0]        o_mz_target;    // cell the blank must reach, [1]=row
    logic [3:0][3:0][3:0]   i_mz_klotski;   // MoveZero result board
    logic                   i_mz_finished;  // result valid this cycle

    modport master (
        output o_mz_start, o_mz_klotski, o_mz_mask, o_mz_target,
        input  i_mz_klotski, i_mz_finished
    );

    modport slave (
        input  o_mz_start, o_mz_klotski, o_mz_mask, o_mz_target,
        output i_mz_klotski, i_mz_finished
    );
endinterface
`default_nettype wire

// File: rtl/move_tile_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : move_tile_ctrl
// Description : Walks one tile to a destination cell one step at a time.
//               Each step routes the blank next to the tile via MoveZero
//               (tile and locked cells masked), then swaps tile and blank.
//               Optional macro MOVE_TILE_CHECK_EN: validate each MoveZero
//               result (blank at target, tile untouched) before swapping.
// Revision    : 1.0 - initial release
// ============================================================================
module move_tile_ctrl #(
    parameter int MAX_STEPS = 16
) (
    input  wire logic                   i_clk,
    input  wire logic                   i_rst,
    input  wire logic                   i_start,
    input  wire logic [3:0][3:0][3:0]   i_klotski,
    input  wire logic [3:0][3:0]        i_lock,
    input  wire logic [3:0]             i_tile,
    input  wire logic [1:0][1:0]        i_dest,
    move_tile_ctrl_if.master            mz,
    output logic [3:0][3:0][3:0]        o_klotski,
    output logic                        o_finished,
    output logic                        o_error
);
    localparam int             CW    = $clog2(MAX_STEPS + 1);
    localparam logic [CW-1:0]  C_MAX = CW'(MAX_STEPS);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOCATE = 3'd1;
    localparam logic [2:0] S_PLAN   = 3'd2;
    localparam logic [2:0] S_KICK   = 3'd3;
    localparam logic [2:0] S_WAIT   = 3'd4;
    localparam logic [2:0] S_SWAP   = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;
    localparam logic [2:0] S_ERR    = 3'd7;

    logic [2:0]             r_state, w_state_nxt;
    logic [3:0][3:0][3:0]   r_work, r_final;
    logic [3:0][3:0]        r_lock, r_mz_mask;
    logic [3:0]             r_tile;
    logic [1:0][1:0]        r_dest;
    logic [1:0]             r_row, r_col, r_nrow, r_ncol;
    logic [CW-1:0]          r_cnt;
    logic                   r_error;

    logic                   w_found;
    logic [1:0]             w_frow, w_fcol, w_nrow, w_ncol;
    logic                   w_at_dest, w_n_locked, w_mz_ok;
    logic [3:0][3:0]        w_onehot;

    // Tile search over the latched board plus next-cell selection (column first)
    always_comb begin
        w_found = 1'b0;
        w_frow  = 2'd0;
        w_fcol  = 2'd0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (r_work[r][c] == r_tile) begin
                    w_found = 1'b1;
                    w_frow  = 2'(r);
                    w_fcol  = 2'(c);
                end
            end
        end
        w_at_dest = (r_row == r_dest[1]) && (r_col == r_dest[0]);
        w_nrow    = r_row;
        w_ncol    = r_col;
        if (r_col != r_dest[0]) begin
            w_ncol = (r_dest[0] > r_col) ? r_col + 2'd1 : r_col - 2'd1;
        end else begin
            w_nrow = (r_dest[1] > r_row) ? r_row + 2'd1 : r_row - 2'd1;
        end
        w_n_locked = r_lock[w_nrow][w_ncol];
        w_onehot   = '0;
        w_onehot[r_row][r_col] = 1'b1;
`ifdef MOVE_TILE_CHECK_EN
        w_mz_ok = (mz.i_mz_klotski[r_nrow][r_ncol] == 4'd0) &&
                  (mz.i_mz_klotski[r_row][r_col] == r_tile);
`else
        w_mz_ok = 1'b1;
`endif
    end

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (i_start) w_state_nxt = S_LOCATE;
            S_LOCATE: w_state_nxt = (w_found && (r_tile != 4'd0)) ? S_PLAN : S_ERR;
            S_PLAN: begin
                if (w_at_dest)                          w_state_nxt = S_DONE;
                else if (w_n_locked || (r_cnt == C_MAX)) w_state_nxt = S_ERR;
                else                                    w_state_nxt = S_KICK;
            end
            S_KICK:   w_state_nxt = S_WAIT;
            S_WAIT:   if (mz.i_mz_finished) w_state_nxt = w_mz_ok ? S_SWAP : S_ERR;
            S_SWAP:   w_state_nxt = S_PLAN;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Job datapath: latch job, track tile position, absorb MoveZero results, swap
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_work    <= '0;
            r_final   <= '0;
            r_lock    <= '0;
            r_mz_mask <= '0;
            r_tile    <= '0;
            r_dest    <= '0;
            r_row     <= '0;
            r_col     <= '0;
            r_nrow    <= '0;
            r_ncol    <= '0;
            r_cnt     <= '0;
            r_error   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (i_start) begin
                    r_work  <= i_klotski;
                    r_lock  <= i_lock;
                    r_tile  <= i_tile;
                    r_dest  <= i_dest;
                    r_cnt   <= '0;
                    r_error <= 1'b0;
                end
                S_LOCATE: begin
                    r_row <= w_frow;
                    r_col <= w_fcol;
                end
                S_PLAN: begin
                    r_nrow    <= w_nrow;
                    r_ncol    <= w_ncol;
                    r_mz_mask <= r_lock | w_onehot;
                end
                S_WAIT: if (mz.i_mz_finished) r_work <= mz.i_mz_klotski;
                S_SWAP: begin
                    r_work[r_nrow][r_ncol] <= r_tile;
                    r_work[r_row][r_col]   <= 4'd0;
                    r_row <= r_nrow;
                    r_col <= r_ncol;
                    r_cnt <= (r_cnt == C_MAX) ? r_cnt : r_cnt + 1'b1;
                end
                S_DONE, S_ERR: r_final <= r_work;
                default: ;
            endcase
            // error flag rises together with the ERR cycle so it is valid with o_finished
            if (w_state_nxt == S_ERR) r_error <= 1'b1;
        end
    end

    // Outputs decoded from state and held job registers
    always_comb begin
        mz.o_mz_start   = (r_state == S_KICK);
        mz.o_mz_klotski = r_work;
        mz.o_mz_mask    = r_mz_mask;
        mz.o_mz_target  = {r_nrow, r_ncol};
        o_finished      = (r_state == S_DONE) || (r_state == S_ERR);
        o_klotski       = o_finished ? r_work : r_final;
        o_error         = r_error;
    end
endmodule
`default_nettype wire

// File: tb/tb_move_tile_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_move_tile_ctrl
// Description : Self-checking bench for move_tile_ctrl with behavioural
//               MoveZero models and a path-walking reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_move_tile_ctrl;
    typedef logic [3:0][3:0][3:0] board_t;
    typedef logic [3:0][3:0]      lock_t;

    logic            i_clk = 1'b0;
    logic            i_rst = 1'b0;
    logic            start1 = 1'b0, start2 = 1'b0;
    board_t          i_klotski = '0;
    lock_t           i_lock = '0;
    logic [3:0]      i_tile = '0;
    logic [1:0][1:0] i_dest = '0;
    board_t          o_kl1, o_kl2;
    logic            fin1, fin2, err1, err2;
    bit              corrupt = 1'b0;
    int              checks = 0, errors = 0;

    always #5 i_clk = ~i_clk;

    move_tile_ctrl_if mz1();
    move_tile_ctrl_if mz2();

    move_tile_ctrl #(.MAX_STEPS(16)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(start1), .i_klotski(i_klotski),
        .i_lock(i_lock), .i_tile(i_tile), .i_dest(i_dest), .mz(mz1.master),
        .o_klotski(o_kl1), .o_finished(fin1), .o_error(err1));

    move_tile_ctrl #(.MAX_STEPS(2)) dut2 (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(start2), .i_klotski(i_klotski),
        .i_lock(i_lock), .i_tile(i_tile), .i_dest(i_dest), .mz(mz2.master),
        .o_klotski(o_kl2), .o_finished(fin2), .o_error(err2));

    // MoveZero behaviour: blank trades places with the target cell
    function automatic board_t mz_model(input board_t b, input logic [1:0][1:0] t, input bit bad);
        board_t res = b;
        if (bad) return b;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (b[r][c] == 4'd0) begin
                    res[r][c]       = b[t[1]][t[0]];
                    res[t[1]][t[0]] = 4'd0;
                end
        return res;
    endfunction

    logic [3:0]  q_t1[$], q_t2[$];
    logic [15:0] q_m1[$], q_m2[$];
    logic [2:0]  m1_cnt, m2_cnt;
    board_t      m1_res, m2_res;

    // MoveZero model for instance 1: finishes 4 cycles after start
    always @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            m1_cnt <= 0; mz1.i_mz_finished <= 1'b0; mz1.i_mz_klotski <= '0;
        end else begin
            mz1.i_mz_finished <= 1'b0;
            if (mz1.o_mz_start) begin
                m1_cnt <= 3;
                m1_res <= mz_model(mz1.o_mz_klotski, mz1.o_mz_target, corrupt);
                q_t1.push_back(mz1.o_mz_target);
                q_m1.push_back(mz1.o_mz_mask);
            end else if (m1_cnt == 1) begin
                mz1.i_mz_finished <= 1'b1; mz1.i_mz_klotski <= m1_res; m1_cnt <= 0;
            end else if (m1_cnt != 0) m1_cnt <= m1_cnt - 1;
        end
    end

    // MoveZero model for instance 2
    always @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            m2_cnt <= 0; mz2.i_mz_finished <= 1'b0; mz2.i_mz_klotski <= '0;
        end else begin
            mz2.i_mz_finished <= 1'b0;
            if (mz2.o_mz_start) begin
                m2_cnt <= 3;
                m2_res <= mz_model(mz2.o_mz_klotski, mz2.o_mz_target, 1'b0);
                q_t2.push_back(mz2.o_mz_target);
                q_m2.push_back(mz2.o_mz_mask);
            end else if (m2_cnt == 1) begin
                mz2.i_mz_finished <= 1'b1; mz2.i_mz_klotski <= m2_res; m2_cnt <= 0;
            end else if (m2_cnt != 0) m2_cnt <= m2_cnt - 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: walk the tile cell by cell, column first
    board_t      exp_board;
    bit          exp_err;
    int          exp_n;
    logic [3:0]  exp_t[32];
    logic [15:0] exp_m[32];

    task automatic ref_job(input board_t b0, input lock_t l, input logic [3:0] tile,
                           input int dr, input int dc, input int maxs, input bit bad);
        board_t b = b0;
        lock_t  m;
        int r = -1, c = -1, nr, nc, steps = 0;
        exp_n = 0; exp_err = 1'b0;
        for (int rr = 0; rr < 4; rr++)
            for (int cc = 0; cc < 4; cc++)
                if (tile != 0 && b[rr][cc] == tile) begin r = rr; c = cc; end
        if (r < 0) begin exp_err = 1'b1; exp_board = b; return; end
        while (!(r == dr && c == dc)) begin
            if (c != dc) begin nr = r; nc = (dc > c) ? c + 1 : c - 1; end
            else         begin nc = c; nr = (dr > r) ? r + 1 : r - 1; end
            if (l[nr][nc] || steps == maxs) begin exp_err = 1'b1; break; end
            m = l; m[r][c] = 1'b1;
            exp_t[exp_n] = {2'(nr), 2'(nc)};
            exp_m[exp_n] = m;
            exp_n++;
            b = mz_model(b, {2'(nr), 2'(nc)}, bad);
            if (bad) begin exp_err = 1'b1; break; end
            b[nr][nc] = tile; b[r][c] = 4'd0;
            r = nr; c = nc; steps++;
        end
        exp_board = b;
    endtask

    function automatic board_t mk_board(input int k);
        board_t b;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) b[r][c] = 4'((r * 4 + c + k) % 16);
        return b;
    endfunction

    function automatic board_t rand_board();
        int v[16];
        board_t b;
        for (int i = 0; i < 16; i++) v[i] = i;
        for (int i = 15; i > 0; i--) begin
            int j = int'($urandom_range(i, 0));
            int t = v[i]; v[i] = v[j]; v[j] = t;
        end
        for (int i = 0; i < 16; i++) b[i / 4][i % 4] = 4'(v[i]);
        return b;
    endfunction

    board_t g_board;
    bit     g_err;
    int     g_lat;

    task automatic run_job(input int inst, input board_t b, input lock_t l, input logic [3:0] tile,
                           input int dr, input int dc, input bit glitch);
        @(posedge i_clk); #1;
        q_t1.delete(); q_m1.delete(); q_t2.delete(); q_m2.delete();
        i_klotski = b; i_lock = l; i_tile = tile; i_dest = {2'(dr), 2'(dc)};
        if (inst == 1) start1 = 1'b1; else start2 = 1'b1;
        g_lat = -1;
        for (int cyc = 1; cyc <= 600; cyc++) begin
            @(posedge i_clk); #1;
            start1 = 1'b0; start2 = 1'b0;
            if ((inst == 1) ? fin1 : fin2) begin
                g_lat   = cyc;
                g_board = (inst == 1) ? o_kl1 : o_kl2;
                g_err   = (inst == 1) ? err1 : err2;
                break;
            end
            if (glitch && cyc == 10) begin
                i_tile = tile ^ 4'hF; i_klotski = ~b;
                if (inst == 1) start1 = 1'b1; else start2 = 1'b1;
            end
        end
        if (g_lat < 0) check("timeout", 64'd0, 64'd1);
    endtask

    task automatic verify(input string tag, input int inst);
        int qn = (inst == 1) ? q_t1.size() : q_t2.size();
        check({tag, "_err"}, g_err, exp_err);
        check({tag, "_board"}, g_board, exp_board);
        check({tag, "_calls"}, qn, exp_n);
        for (int i = 0; i < exp_n && i < qn; i++) begin
            check({tag, "_target"}, (inst == 1) ? q_t1[i] : q_t2[i], exp_t[i]);
            check({tag, "_mask"},   (inst == 1) ? q_m1[i] : q_m2[i], exp_m[i]);
        end
    endtask

    initial begin
        board_t b;
        lock_t  l;
        logic [3:0] tile;
        int dr, dc, w;

        #1 i_rst = 1'b1;
        repeat (3) @(posedge i_clk);
        #1;
        check("rst_finished", fin1, 1'b0);
        check("rst_error", err1, 1'b0);
        check("rst_klotski", o_kl1, 64'd0);
        check("rst_mz_start", mz1.o_mz_start, 1'b0);
        check("rst_mz_board", mz1.o_mz_klotski, 64'd0);
        i_rst = 1'b0;

        // already at destination
        b = mk_board(15);
        run_job(1, b, '0, 4'd5, 1, 2, 1'b0);
        ref_job(b, '0, 4'd5, 1, 2, 16, 1'b0);
        verify("c1", 1);
        check("c1_latency", g_lat, 3);
        @(posedge i_clk); #1;
        check("c1_pulse_len", fin1, 1'b0);

        // locked neighbour on the path
        b = mk_board(1); l = '0; l[1][0] = 1'b1;
        run_job(1, b, l, 4'd9, 0, 0, 1'b0);
        ref_job(b, l, 4'd9, 0, 0, 16, 1'b0);
        verify("c3", 1);

        // four-step walk, also confirms error clears on new start
        b = mk_board(8);
        run_job(1, b, '0, 4'd7, 1, 1, 1'b0);
        ref_job(b, '0, 4'd7, 1, 1, 16, 1'b0);
        verify("c2", 1);

        // tile absent from board
        b = mk_board(1); b[2][3] = 4'd0;
        run_job(1, b, '0, 4'd12, 0, 0, 1'b0);
        ref_job(b, '0, 4'd12, 0, 0, 16, 1'b0);
        verify("c4", 1);
        check("c4_latency", g_lat, 2);

        // step limit with a stray start mid-job
        b = mk_board(3);
        run_job(2, b, '0, 4'd3, 0, 3, 1'b1);
        ref_job(b, '0, 4'd3, 0, 3, 2, 1'b0);
        verify("c5", 2);

        // reset while waiting on MoveZero, then rerun the walk
        @(posedge i_clk); #1;
        q_t1.delete(); q_m1.delete();
        b = mk_board(8);
        i_klotski = b; i_lock = '0; i_tile = 4'd7; i_dest = {2'd1, 2'd1};
        start1 = 1'b1;
        @(posedge i_clk); #1;
        start1 = 1'b0;
        w = 0;
        while (q_t1.size() == 0 && w < 50) begin @(posedge i_clk); #1; w++; end
        check("c6_kick_seen", q_t1.size() > 0, 1'b1);
        @(posedge i_clk); #3;
        i_rst = 1'b1;
        #1;
        check("c6_rst_finished", fin1, 1'b0);
        check("c6_rst_klotski", o_kl1, 64'd0);
        check("c6_rst_mz_start", mz1.o_mz_start, 1'b0);
        check("c6_rst_mz_board", mz1.o_mz_klotski, 64'd0);
        check("c6_rst_mz_mask", mz1.o_mz_mask, 16'd0);
        check("c6_rst_mz_target", mz1.o_mz_target, 4'd0);
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        run_job(1, b, '0, 4'd7, 1, 1, 1'b0);
        ref_job(b, '0, 4'd7, 1, 1, 16, 1'b0);
        verify("c6", 1);

        // randomized jobs
        for (int n = 0; n < 12; n++) begin
            b = rand_board();
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) l[r][c] = ($urandom_range(7, 0) == 0);
            tile = 4'($urandom_range(15, 1));
            dr = int'($urandom_range(3, 0));
            dc = int'($urandom_range(3, 0));
            run_job(1, b, l, tile, dr, dc, 1'b0);
            ref_job(b, l, tile, dr, dc, 16, 1'b0);
            verify("rnd", 1);
        end

`ifdef MOVE_TILE_CHECK_EN
        // MoveZero returns a board with the blank elsewhere
        corrupt = 1'b1;
        b = mk_board(8);
        run_job(1, b, '0, 4'd7, 1, 1, 1'b0);
        ref_job(b, '0, 4'd7, 1, 1, 16, 1'b1);
        verify("chk", 1);
        corrupt = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
